// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, defaults and constants for the instruction prefetch unit
package fetch_pkg;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int PC_INC     = 4;
  typedef enum logic [1:0] {IDLE, REQ, FULL} fetch_state_t;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fifo_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push, pop and priority flush; head read straight from storage
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  // Flush only rewinds pointers; stale storage stays hidden behind a zero count
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: req/ack instruction fetch into a prefetch FIFO with redirect flush
// Optional FETCH_BYPASS_EN: an acked word is presented in its ack cycle when the FIFO is empty
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] startPC,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] InstrPC
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t               state_q;
  logic [ADDR_W-1:0]          addr_q, rpc_q, rpc_al;
  logic                       discard_q, ack, push, pop, byp;
  logic [CW-1:0]              count, count_next;
  logic [DATA_W+ADDR_W-1:0]   head;
  assign ack        = MemAck && state_q == REQ;
  assign rpc_al     = RedirectPC & ~ADDR_W'(3);
`ifdef FETCH_BYPASS_EN
  assign byp        = ack && !discard_q && !Redirect && count == '0;
`else
  assign byp        = 1'b0;
`endif
  assign push       = ack && !discard_q && !Redirect && !(byp && InstrReady);
  assign pop        = count != '0 && InstrReady && !Redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  assign MemReq     = state_q == REQ;
  assign MemAddr    = addr_q;
  assign InstrValid = count != '0 || byp;
  assign {Instruction, InstrPC} = byp ? {MemData, addr_q} : head;
  fetch_fifo #(.DEPTH(DEPTH), .W(DATA_W + ADDR_W)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (Redirect),
    .wdata_i ({MemData, addr_q}),
    .rdata_o (head),
    .count_o (count)
  );
  // Fetch FSM: request address is held until ack; a redirect during an outstanding request is parked in rpc_q
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state_q   <= IDLE;
      addr_q    <= startPC;
      rpc_q     <= '0;
      discard_q <= 1'b0;
    end else if (Redirect) begin
      state_q <= REQ;
      if (state_q == REQ && !ack) begin
        discard_q <= 1'b1;
        rpc_q     <= rpc_al;
      end else begin
        discard_q <= 1'b0;
        addr_q    <= rpc_al;
      end
    end else if (ack) begin
      discard_q <= 1'b0;
      addr_q    <= discard_q ? rpc_q : addr_q + ADDR_W'(PC_INC);
      state_q   <= count_next < CW'(DEPTH) ? REQ : FULL;
    end else if (state_q != REQ) begin
      state_q <= (state_q == IDLE || count < CW'(DEPTH)) ? REQ : FULL;
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed table, corner sequences and randomized queue-model check of the prefetch unit
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic CLK = 1'b0;
  logic Reset = 1'b1, Redirect = 1'b0, MemAck = 1'b0, InstrReady = 1'b0;
  logic MemReq, InstrValid;
  logic [AW-1:0] startPC = '0, RedirectPC = '0, MemAddr, InstrPC;
  logic [DW-1:0] MemData = '0, Instruction;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .Reset(Reset), .startPC(startPC), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instruction(Instruction), .InstrPC(InstrPC)
  );

  always @(posedge CLK)
    if (!Reset && MemAck && !MemReq) begin
      errors++;
      $display("FAIL ack_without_req: MemAck=1 while MemReq=0");
    end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chkb(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  // One cycle: inputs applied at the falling edge; memory only acks a live request
  task automatic drive(input logic r, input logic [AW-1:0] rpc, input logic ack, input logic rdy);
    @(negedge CLK);
    Redirect   = r;
    RedirectPC = rpc;
    MemAck     = ack && MemReq;
    InstrReady = rdy;
    MemData    = MemAck ? memf(MemAddr) : $urandom;
    #1;
  endtask

  task automatic do_reset(input logic [AW-1:0] spc);
    @(negedge CLK);
    Reset = 1'b1; startPC = spc; Redirect = 1'b0; MemAck = 1'b0; InstrReady = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic          ack;
    logic          rdy;
    logic          req;
    logic [AW-1:0] addr;
    logic          vld;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t tbl [7];
  fifo_entry_t q [$];
  fifo_entry_t h;
  logic [AW-1:0] exp_a, tgt, cap;
  logic drop, r, bp, ev;
  int acks, reqs, delivered, thr;

  initial begin
    // Sequential fetch from 0x40, each request acked one cycle after it rises, consumer always ready
    tbl = '{
      '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0},
      '{1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0},
      '{1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h40},
      '{1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0},
      '{1'b0, 1'b1, 1'b1, 32'h48, 1'b1, 32'h44},
      '{1'b1, 1'b1, 1'b1, 32'h48, 1'b0, 32'h0},
      '{1'b0, 1'b1, 1'b1, 32'h4C, 1'b1, 32'h48}
    };
    do_reset(32'h40);
    chkb("rst_memreq", MemReq, 1'b0);
    chkb("rst_valid", InstrValid, 1'b0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc", InstrPC, 32'h0);
    chk("rst_addr", MemAddr, 32'h40);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, '0, tbl[i].ack, tbl[i].rdy);
      chkb("tbl_req", MemReq, tbl[i].req);
      if (tbl[i].req) chk("tbl_addr", MemAddr, tbl[i].addr);
`ifndef FETCH_BYPASS_EN
      chkb("tbl_valid", InstrValid, tbl[i].vld);
`endif
      if (tbl[i].vld) begin
        chk("tbl_pc", InstrPC, tbl[i].pc);
        chk("tbl_instr", Instruction, memf(tbl[i].pc));
      end
    end

    // Fill with a stalled consumer and an immediately-acking memory
    do_reset(32'h1000);
    acks = 0;
    repeat (10) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (MemAck) acks++;
    end
    chk("full_acks", acks, 4);
    chkb("full_memreq", MemReq, 1'b0);
    chkb("full_valid", InstrValid, 1'b1);
    chk("full_head", InstrPC, 32'h1000);
    drive(1'b0, '0, 1'b1, 1'b1);
    reqs = 0;
    cap  = '0;
    repeat (8) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (MemAck) begin
        reqs++;
        cap = MemAddr;
      end
    end
    chk("refill_reqs", reqs, 1);
    chk("refill_addr", cap, 32'h1010);
    chk("refill_head", InstrPC, 32'h1004);

    // Redirect (unaligned target) while a slow request is outstanding
    do_reset(32'h40);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h202, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chkb("rdo_hold_req", MemReq, 1'b1);
    chk("rdo_hold_addr", MemAddr, 32'h40);
    chkb("rdo_flush_valid", InstrValid, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("rdo_ack_addr", MemAddr, 32'h40);
    drive(1'b0, '0, 1'b1, 1'b1);
    chkb("rdo_drop_valid", InstrValid, 1'b0);
    chk("rdo_new_addr", MemAddr, 32'h200);
    drive(1'b0, '0, 1'b0, 1'b1);
    chkb("rdo_first_valid", InstrValid, 1'b1);
    chk("rdo_first_pc", InstrPC, 32'h200);

    // Redirect coinciding with the ack
    do_reset(32'h40);
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    chkb("rda_valid", InstrValid, 1'b0);
    chk("rda_addr", MemAddr, 32'h100);
    drive(1'b0, '0, 1'b0, 1'b1);
    chkb("rda_next_valid", InstrValid, 1'b1);
    chk("rda_next_pc", InstrPC, 32'h100);

    // Asynchronous reset in the middle of a request with three words buffered
    do_reset(32'h40);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chkb("arst_pre_req", MemReq, 1'b1);
    chkb("arst_pre_valid", InstrValid, 1'b1);
    #1;
    Reset   = 1'b1;
    startPC = 32'h800;
    #1;
    chkb("arst_req", MemReq, 1'b0);
    chkb("arst_valid", InstrValid, 1'b0);
    chk("arst_instr", Instruction, 32'h0);
    chk("arst_pc", InstrPC, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    drive(1'b0, '0, 1'b0, 1'b1);
    chkb("arst_rel_req", MemReq, 1'b1);
    chk("arst_rel_addr", MemAddr, 32'h800);

    // Latency of an ack into an empty FIFO
    do_reset(32'h40);
    drive(1'b0, '0, 1'b1, 1'b1);
`ifdef FETCH_BYPASS_EN
    chkb("byp_valid", InstrValid, 1'b1);
    chk("byp_instr", Instruction, memf(32'h40));
    drive(1'b0, '0, 1'b0, 1'b1);
    chkb("byp_consumed", InstrValid, 1'b0);
`else
    chkb("lat_ack_cycle", InstrValid, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    chkb("lat_next_valid", InstrValid, 1'b1);
    chk("lat_next_pc", InstrPC, 32'h40);
`endif

    // Randomized traffic against a queue-level reference model
    do_reset({$urandom_range(0, 32'hFFFF), 2'b00});
    q.delete();
    exp_a     = startPC;
    tgt       = '0;
    drop      = 1'b0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      thr = ((c / 500) % 2) != 0 ? 20 : 85;
      r   = $urandom_range(0, 24) == 0;
      drive(r, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 99) < thr);
      bp = BYP && MemAck && !drop && !Redirect && q.size() == 0;
      ev = q.size() != 0 || bp;
      chkb("rnd_valid", InstrValid, ev);
      if (q.size() != 0) begin
        h = q[0];
        chk("rnd_pc", InstrPC, h.pc);
        chk("rnd_instr", Instruction, h.instr);
      end else if (bp) begin
        chk("rnd_byp_pc", InstrPC, exp_a);
        chk("rnd_byp_instr", Instruction, memf(exp_a));
      end
      if (MemReq) begin
        chk("rnd_addr", MemAddr, exp_a);
        chkb("rnd_issue", q.size() < DEPTH, 1'b1);
      end
      if (Redirect) begin
        q.delete();
        tgt = RedirectPC & ~32'd3;
        if (MemReq && !MemAck) drop = 1'b1;
        else begin
          drop  = 1'b0;
          exp_a = tgt;
        end
      end else begin
        if (InstrReady && q.size() != 0) begin
          void'(q.pop_front());
          delivered++;
        end
        if (MemAck) begin
          if (drop) begin
            drop  = 1'b0;
            exp_a = tgt;
          end else begin
            if (bp && InstrReady) delivered++;
            else q.push_back(fifo_entry_t'{instr: memf(exp_a), pc: exp_a});
            exp_a = exp_a + 32'd4;
          end
        end
      end
    end
    chkb("rnd_progress", delivered > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the single-cycle datapath's decode/control logic.
- Issues word fetches to instruction memory over a req/ack handshake and buffers returned words with their PCs in a small FIFO.
- Presents one instruction per cycle to the datapath with a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding any in-flight response.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- startPC  input  ADDR_W  fetch address loaded while Reset is high.
- Redirect  input  1  taken branch/jump this cycle.
- RedirectPC  input  ADDR_W  new fetch address, valid with Redirect.
- MemReq  output  1  fetch request to instruction memory.
- MemAddr  output  ADDR_W  word address of the request.
- MemAck  input  1  request complete; MemData valid this cycle.
- MemData  input  DATA_W  fetched instruction.
- InstrValid  output  1  Instruction/InstrPC valid.
- InstrReady  input  1  consumer accepts the head entry.
- Instruction  output  DATA_W  head instruction.
- InstrPC  output  ADDR_W  PC of the head instruction.

Behaviour:
- Reset values (asynchronous, active-high):
  - MemReq=0, InstrValid=0, Instruction=0, InstrPC=0.
  - FIFO empty, count=0, discard flag=0, state IDLE.
  - Fetch pointer fpc=startPC.
- State machine:
  - IDLE: first cycle after Reset deasserts goes to REQ.
  - REQ: MemReq=1, MemAddr=fpc, both held stable until MemAck.
    - On MemAck: fpc+=4 (wraps modulo 2^ADDR_W).
    - Next state is REQ if count_next+0 < DEPTH, else FULL.
  - FULL: MemReq=0; returns to REQ when count < DEPTH.
- Issue rule: a new request is raised only if count + outstanding(0/1) < DEPTH.
  - At most one request is outstanding.
  - The FIFO can never overflow.
- Push: on MemAck with discard=0, write {MemData, MemAddr} into the FIFO.
- Pop: when InstrValid && InstrReady.
- Simultaneous push and pop: count unchanged, order preserved.
- Latency: data acked in cycle N is visible on Instruction in cycle N+1 when the FIFO was empty.
- InstrValid = (count != 0). Instruction/InstrPC are driven from the FIFO head (registered storage).
- Redirect, when not in the same cycle as MemAck:
  - FIFO flushed (count=0) next cycle.
  - fpc=RedirectPC.
  - If a request is outstanding: discard=1, and MemReq/MemAddr stay held until MemAck.
  - The acked word is dropped, discard clears, and the next request uses RedirectPC.
  - If no request is outstanding: next cycle is REQ with MemAddr=RedirectPC.
- Redirect in the same cycle as MemAck: the acked word is dropped, discard stays 0, and the next cycle requests RedirectPC.
- Redirect has priority over pop and push.
- InstrValid=0 in the cycle after a redirect.
- Redirect in consecutive cycles: the last RedirectPC wins.
- MemAck while MemReq=0: ignored; this is an assertion error in the bench.
- RedirectPC[1:0] != 0: forced to 0 (word-aligned).

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty (or just flushed is not applicable) and MemAck arrives with discard=0 and no Redirect, InstrValid=1 in the same cycle with Instruction=MemData and InstrPC=MemAddr.
  - If InstrReady is also 1, the word is not written into the FIFO. Otherwise it is pushed as normal.
  - Zero-cycle fetch latency.
- Undefined: all outputs registered from FIFO storage; one-cycle latency as above.

Decomposition:
- Package fetch_pkg contains:
  - fetch_state_t enum {IDLE, REQ, FULL}.
  - Constant PC_INC=4.
  - Default DEPTH/ADDR_W/DATA_W.
  - fifo_entry_t struct {instr, pc}.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO with push, pop and flush.
  - Count output; read/write pointers wrap modulo DEPTH.
  - Flush has priority.

Test Plan:
- Reset with startPC=0x0000_0040, MemAck one cycle after each MemReq, InstrReady=1 -> MemAddr sequence 0x40, 0x44, 0x48; InstrPC follows the same sequence, one cycle after each ack.
- InstrReady=0, memory acks immediately, DEPTH=4 -> exactly 4 acks, then MemReq=0 and FULL. Raising InstrReady for 1 cycle -> exactly one new request, to startPC+0x10.
- Memory ack delay of 3 cycles, Redirect to 0x200 in the 2nd wait cycle -> MemAddr held at the old address until ack, that word not delivered, next MemAddr=0x200, first InstrPC after the redirect is 0x200.
- Redirect to 0x100 in the same cycle as MemAck -> acked word dropped, InstrValid=0 next cycle, next MemAddr=0x100.
- Reset asserted mid-request (MemReq=1, count=3) -> MemReq, InstrValid and count are 0 immediately (asynchronous). After release the first MemAddr equals the new startPC.
- With FETCH_BYPASS_EN, FIFO empty, ack with MemData=0x2008_0005 and InstrReady=1 -> InstrValid=1 and Instruction=0x2008_0005 in the ack cycle; count stays 0.
